// File: rtl/seg_disp_pkg.sv
// ============================================================================
// Module   : seg_disp_pkg
// Brief    : Shared types and constants for the seven-segment display arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

package seg_disp_pkg;

    localparam int DIGIT_W    = 4;
    localparam int NUM_DIGITS = 6;
    localparam int DISP_W     = DIGIT_W * NUM_DIGITS;
    localparam int MAX_REQ    = 8;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SHOW = 1'b1
    } seg_state_e;

    function automatic logic [MAX_REQ-1:0] onehot8(input logic [2:0] idx);
        onehot8      = '0;
        onehot8[idx] = 1'b1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/seg_rr_pick.sv
// ============================================================================
// Module   : seg_rr_pick
// Brief    : Finds the first set bit at or after a start index, wrapping.
// Revision : 1.0
// ============================================================================
`default_nettype none

module seg_rr_pick #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] pending,
    input  logic [2:0]         start,
    output logic               found,
    output logic [2:0]         idx
);

    int w_j;

    // Scan from the far end so the nearest candidate is the last writer.
    always_comb begin
        found = 1'b0;
        idx   = 3'd0;
        w_j   = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_j = int'(start) + k;
            if (w_j >= NUM_REQ) w_j = w_j - NUM_REQ;
            if (pending[w_j]) begin
                found = 1'b1;
                idx   = 3'(w_j);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/seg_disp_arbiter.sv
// ============================================================================
// Module   : seg_disp_arbiter
// Brief    : Round-robin owner arbitration with dwell time for a shared 6-digit
//            display, plus a free-running scan tick. Optional lock input is
//            enabled by defining SEG_DISP_ARB_LOCK_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module seg_disp_arbiter
    import seg_disp_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int DWELL_CYCLES = 50_000_000,
    parameter int SCAN_DIV     = 50_000
) (
    input  logic                      clk,
    input  logic                      rstn,
`ifdef SEG_DISP_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]        lock,
`endif
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DISP_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        grant,
    output logic [2:0]                owner_id,
    output logic [DISP_W-1:0]         disp_data,
    output logic                      disp_valid,
    output logic                      scan_tick
);

    localparam int DW = $clog2(DWELL_CYCLES);
    localparam int SW = $clog2(SCAN_DIV);
    localparam logic [DW-1:0] C_DWELL_MAX = DW'(DWELL_CYCLES - 1);
    localparam logic [SW-1:0] C_SCAN_MAX  = SW'(SCAN_DIV - 1);

    seg_state_e          r_state, w_next_state;
    logic [2:0]          r_owner, w_next_owner;
    logic [2:0]          r_rr_ptr, w_next_rr;
    logic [DW-1:0]       r_dwell, w_next_dwell;
    logic [SW-1:0]       r_scan_cnt;
    logic [NUM_REQ-1:0]  r_grant;
    logic [DISP_W-1:0]   r_disp_data, w_next_data;
    logic                r_disp_valid;

    logic [MAX_REQ-1:0]  w_owner_oh8, w_next_oh8;
    logic [NUM_REQ-1:0]  w_owner_oh, w_others, w_pick_pend;
    logic [2:0]          w_owner_inc, w_pick_start, w_pick_idx;
    logic                w_found, w_owner_req, w_dwell_exp, w_locked;
    logic                w_unused_oh;

    assign w_owner_oh8 = onehot8(r_owner);
    assign w_next_oh8  = onehot8(w_next_owner);
    assign w_owner_oh  = w_owner_oh8[NUM_REQ-1:0];
    assign w_unused_oh = ^{w_owner_oh8, w_next_oh8};

    assign w_owner_req = |(req & w_owner_oh);
    assign w_others    = req & ~w_owner_oh;
    assign w_owner_inc = (r_owner == 3'(NUM_REQ - 1)) ? 3'd0 : r_owner + 3'd1;
    assign w_dwell_exp = (r_dwell == C_DWELL_MAX);

`ifdef SEG_DISP_ARB_LOCK_EN
    assign w_locked = |(lock & w_owner_oh);
`else
    assign w_locked = 1'b0;
`endif

    // IDLE starts the search at the rr pointer; SHOW searches past the owner.
    assign w_pick_pend  = (r_state == IDLE) ? req : w_others;
    assign w_pick_start = (r_state == IDLE) ? r_rr_ptr : w_owner_inc;

    seg_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .pending (w_pick_pend),
        .start   (w_pick_start),
        .found   (w_found),
        .idx     (w_pick_idx)
    );

    always_comb begin
        w_next_state = r_state;
        w_next_owner = r_owner;
        w_next_dwell = r_dwell;
        w_next_rr    = r_rr_ptr;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_next_state = SHOW;
                    w_next_owner = w_pick_idx;
                    w_next_dwell = '0;
                end
            end
            SHOW: begin
                if (!w_owner_req) begin
                    w_next_dwell = '0;
                    if (w_found) begin
                        w_next_owner = w_pick_idx;
                    end else begin
                        w_next_state = IDLE;
                        w_next_owner = 3'd0;
                    end
                end else if (w_dwell_exp && w_found && !w_locked) begin
                    w_next_owner = w_pick_idx;
                    w_next_dwell = '0;
                    w_next_rr    = (w_pick_idx == 3'(NUM_REQ - 1)) ? 3'd0 : w_pick_idx + 3'd1;
                end else if (!w_dwell_exp) begin
                    w_next_dwell = r_dwell + 1'b1;
                end
            end
            default: begin
                w_next_state = IDLE;
                w_next_owner = 3'd0;
            end
        endcase
    end

    always_comb begin
        w_next_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_next_owner == 3'(i)) w_next_data = req_data[i*DISP_W +: DISP_W];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state      <= IDLE;
            r_owner      <= 3'd0;
            r_rr_ptr     <= 3'd0;
            r_dwell      <= '0;
            r_grant      <= '0;
            r_disp_data  <= '0;
            r_disp_valid <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_owner      <= w_next_owner;
            r_rr_ptr     <= w_next_rr;
            r_dwell      <= w_next_dwell;
            r_disp_valid <= (w_next_state == SHOW);
            r_grant      <= (w_next_state == SHOW) ? w_next_oh8[NUM_REQ-1:0] : '0;
            // Going idle keeps the last word on the display.
            if (w_next_state == SHOW) r_disp_data <= w_next_data;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_scan_cnt <= '0;
        end else if (r_scan_cnt == C_SCAN_MAX) begin
            r_scan_cnt <= '0;
        end else begin
            r_scan_cnt <= r_scan_cnt + 1'b1;
        end
    end

    assign scan_tick  = (r_scan_cnt == C_SCAN_MAX);
    assign grant      = r_grant;
    assign owner_id   = r_owner;
    assign disp_data  = r_disp_data;
    assign disp_valid = r_disp_valid;

endmodule

`default_nettype wire
